// File: rtl/stdp_pkg.sv
// Shared types and constants for the STDP pair scheduler.
// The update payload struct uses index fields wide enough for any supported neuron count.
package stdp_pkg;

    localparam int DT_W           = 6;
    localparam int HIST_W_DEFAULT = 16;
    localparam int IDX_MAX_W      = 8;
    localparam int PERF_W         = 16;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        EVAL,
        ISSUE,
        DONE
    } state_t;

    typedef struct packed {
        logic [IDX_MAX_W-1:0]   pre;
        logic [IDX_MAX_W-1:0]   post;
        logic signed [DT_W-1:0] dt;
    } upd_payload_t;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] value);
        return (value == {PERF_W{1'b1}}) ? value : value + PERF_W'(1);
    endfunction

endpackage

// File: rtl/stdp_pair_counter.sv
// Nested (pre inner, post outer) index counter for the STDP pair scan.
module stdp_pair_counter #(
    parameter int N_PRE   = 4,
    parameter int N_POST  = 4,
    parameter int PRE_AW  = (N_PRE  > 1) ? $clog2(N_PRE)  : 1,
    parameter int POST_AW = (N_POST > 1) ? $clog2(N_POST) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               advance,
    output logic [PRE_AW-1:0]  pre_idx,
    output logic [POST_AW-1:0] post_idx,
    output logic               last
);

    localparam logic [PRE_AW-1:0]  PRE_LAST  = PRE_AW'(N_PRE - 1);
    localparam logic [POST_AW-1:0] POST_LAST = POST_AW'(N_POST - 1);

    logic pre_wrap;
    logic post_wrap;

    assign pre_wrap  = (pre_idx == PRE_LAST);
    assign post_wrap = (post_idx == POST_LAST);
    assign last      = pre_wrap && post_wrap;

    // Post only moves when pre wraps; the full wrap back to (0,0) is harmless since the FSM stops there.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_idx  <= '0;
            post_idx <= '0;
        end else if (clear) begin
            pre_idx  <= '0;
            post_idx <= '0;
        end else if (advance) begin
            if (pre_wrap) begin
                pre_idx  <= '0;
                post_idx <= post_wrap ? '0 : post_idx + POST_AW'(1);
            end else begin
                pre_idx <= pre_idx + PRE_AW'(1);
            end
        end
    end

endmodule

// File: rtl/stdp_pair_scheduler.sv
// Per-timestep scan over all (pre, post) synapse pairs, issuing non-zero dt as update requests.
// Optional STDP_PERF_CNT_EN adds saturating upd_count / pair_count outputs.
module stdp_pair_scheduler
    import stdp_pkg::*;
#(
    parameter int N_PRE   = 4,
    parameter int N_POST  = 4,
    parameter int HIST_W  = HIST_W_DEFAULT,
    parameter int PRE_AW  = (N_PRE  > 1) ? $clog2(N_PRE)  : 1,
    parameter int POST_AW = (N_POST > 1) ? $clog2(N_POST) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic                   hist_rd_en,
    output logic [PRE_AW-1:0]      pre_addr,
    output logic [POST_AW-1:0]     post_addr,
    input  logic [HIST_W-1:0]      pre_data,
    input  logic [HIST_W-1:0]      post_data,
    output logic [HIST_W-1:0]      dif_pre,
    output logic [HIST_W-1:0]      dif_post,
    input  logic signed [DT_W-1:0] dif_dt,
    output logic                   upd_valid,
    input  logic                   upd_ready,
    output logic [PRE_AW-1:0]      upd_pre,
    output logic [POST_AW-1:0]     upd_post,
    output logic signed [DT_W-1:0] upd_dt
`ifdef STDP_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]      upd_count,
    output logic [PERF_W-1:0]      pair_count
`endif
);

    state_t             state;
    logic               start_ok;
    logic               dt_nonzero;
    logic               handshake;
    logic               advance;
    logic               last;
    logic [PRE_AW-1:0]  pre_idx;
    logic [POST_AW-1:0] post_idx;

    assign start_ok   = (state == IDLE) && start && !abort;
    assign dt_nonzero = (dif_dt != '0);
    assign handshake  = (state == ISSUE) && upd_ready && !abort;
    assign advance    = !abort && (((state == EVAL) && !dt_nonzero) || handshake);

    assign pre_addr  = pre_idx;
    assign post_addr = post_idx;

    stdp_pair_counter #(
        .N_PRE   (N_PRE),
        .N_POST  (N_POST),
        .PRE_AW  (PRE_AW),
        .POST_AW (POST_AW)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (start_ok),
        .advance  (advance),
        .pre_idx  (pre_idx),
        .post_idx (post_idx),
        .last     (last)
    );

    // hist_rd_en and done are single-cycle strobes, so they default low every cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            hist_rd_en <= 1'b0;
            dif_pre    <= '0;
            dif_post   <= '0;
            upd_valid  <= 1'b0;
            upd_pre    <= '0;
            upd_post   <= '0;
            upd_dt     <= '0;
        end else begin
            done       <= 1'b0;
            hist_rd_en <= 1'b0;
            if (abort && (state != IDLE)) begin
                state     <= IDLE;
                busy      <= 1'b0;
                upd_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_ok) begin
                            state      <= READ;
                            busy       <= 1'b1;
                            hist_rd_en <= 1'b1;
                        end
                    end
                    READ: begin
                        state <= LATCH;
                    end
                    LATCH: begin
                        dif_pre  <= pre_data;
                        dif_post <= post_data;
                        state    <= EVAL;
                    end
                    EVAL: begin
                        if (dt_nonzero) begin
                            upd_pre   <= pre_idx;
                            upd_post  <= post_idx;
                            upd_dt    <= dif_dt;
                            upd_valid <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (handshake) begin
                            upd_valid <= 1'b0;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase

                // Leaving a pair: either finish the scan or go read the next pair.
                if (advance) begin
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state      <= READ;
                        hist_rd_en <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef STDP_PERF_CNT_EN
    // Counters restart on an accepted start and keep their values once the scan ends.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            upd_count  <= '0;
            pair_count <= '0;
        end else if (start_ok) begin
            upd_count  <= '0;
            pair_count <= '0;
        end else begin
            if (handshake) begin
                upd_count <= sat_inc(upd_count);
            end
            if (advance) begin
                pair_count <= sat_inc(pair_count);
            end
        end
    end
`endif

endmodule

// File: tb/tb_stdp_pair_scheduler.sv
// Directed bench for stdp_pair_scheduler (N_PRE=4, N_POST=2) with a behavioural spike-timing datapath model.
module tb_stdp_pair_scheduler;
    import stdp_pkg::*;

    localparam int N_PRE   = 4;
    localparam int N_POST  = 2;
    localparam int PRE_AW  = 2;
    localparam int POST_AW = 1;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   start = 1'b0;
    logic                   abort = 1'b0;
    logic                   upd_ready = 1'b1;
    logic                   busy;
    logic                   done;
    logic                   hist_rd_en;
    logic [PRE_AW-1:0]      pre_addr;
    logic [POST_AW-1:0]     post_addr;
    logic [15:0]            pre_data = '0;
    logic [15:0]            post_data = '0;
    logic [15:0]            dif_pre;
    logic [15:0]            dif_post;
    logic signed [DT_W-1:0] dif_dt;
    logic                   upd_valid;
    logic [PRE_AW-1:0]      upd_pre;
    logic [POST_AW-1:0]     upd_post;
    logic signed [DT_W-1:0] upd_dt;
`ifdef STDP_PERF_CNT_EN
    logic [15:0]            upd_count;
    logic [15:0]            pair_count;
`endif

    logic [15:0]  pre_mem [N_PRE];
    logic [15:0]  post_mem [N_POST];
    upd_payload_t upd_q [$];
    int           addr_q [$];
    int           checks = 0;
    int           errors = 0;

    stdp_pair_scheduler #(
        .N_PRE  (N_PRE),
        .N_POST (N_POST),
        .HIST_W (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .hist_rd_en (hist_rd_en),
        .pre_addr   (pre_addr),
        .post_addr  (post_addr),
        .pre_data   (pre_data),
        .post_data  (post_data),
        .dif_pre    (dif_pre),
        .dif_post   (dif_post),
        .dif_dt     (dif_dt),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_pre    (upd_pre),
        .upd_post   (upd_post),
        .upd_dt     (upd_dt)
`ifdef STDP_PERF_CNT_EN
        ,
        .upd_count  (upd_count),
        .pair_count (pair_count)
`endif
    );

    always #5 clk = ~clk;

    // History memories with one cycle of read latency.
    always @(posedge clk) begin
        if (hist_rd_en) begin
            pre_data  <= pre_mem[pre_addr];
            post_data <= post_mem[post_addr];
        end
    end

    // dt = age of latest pre spike minus age of latest post spike; 0 if either history is empty.
    function automatic logic signed [DT_W-1:0] model_dt(input logic [15:0] p, input logic [15:0] q);
        int ap;
        int aq;
        ap = -1;
        aq = -1;
        for (int i = 0; i < 16; i++) begin
            if (p[i]) ap = 15 - i;
            if (q[i]) aq = 15 - i;
        end
        if (ap < 0 || aq < 0) return '0;
        return DT_W'(ap - aq);
    endfunction

    always_comb dif_dt = model_dt(dif_pre, dif_post);

    always @(posedge clk) begin
        if (reset && upd_valid && upd_ready)
            upd_q.push_back('{pre: IDX_MAX_W'(upd_pre), post: IDX_MAX_W'(upd_post), dt: upd_dt});
        if (reset && hist_rd_en)
            addr_q.push_back(int'(pre_addr) + 16 * int'(post_addr));
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic load_hist(input logic [15:0] p0, input logic [15:0] p1, input logic [15:0] p2,
                             input logic [15:0] p3, input logic [15:0] q0, input logic [15:0] q1);
        pre_mem[0]  = p0;
        pre_mem[1]  = p1;
        pre_mem[2]  = p2;
        pre_mem[3]  = p3;
        post_mem[0] = q0;
        post_mem[1] = q1;
    endtask

    // Called at a negedge; cycles counts negedges after the start pulse until done is seen.
    task automatic run_scan(input int budget, input int restart_at, output int cycles, output int busy_n);
        busy_n = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 1;
        while (!done && cycles < budget) begin
            if (busy) busy_n++;
            start = (cycles == restart_at);
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
    endtask

    int  cycles;
    int  busy_n;
    int  vcycles;
    int  n;
    bit  stable;
    bit  saw_done;

    initial begin
        load_hist(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", hist_rd_en, 0);
        check("rst_pre_addr", pre_addr, 0);
        check("rst_post_addr", post_addr, 0);
        check("rst_dif_pre", dif_pre, 0);
        check("rst_dif_post", dif_post, 0);
        check("rst_upd_valid", upd_valid, 0);
        check("rst_upd_payload", {upd_pre, upd_post, upd_dt}, 0);
        reset = 1'b1;
        @(negedge clk);

        // Idle scan: all histories empty
        upd_q.delete();
        run_scan(100, 0, cycles, busy_n);
        check("idle_done_latency", cycles, 25);
        check("idle_busy_cycles", busy_n, 24);
        check("idle_busy_low_at_done", busy, 0);
        check("idle_no_updates", upd_q.size(), 0);
        @(negedge clk);
        check("idle_done_one_cycle", done, 0);

        // Single potentiation at (2,0)
        load_hist(16'h0, 16'h0, 16'h0800, 16'h0, 16'h8000, 16'h0);
        upd_q.delete();
        run_scan(100, 0, cycles, busy_n);
        check("pot_done_latency", cycles, 26);
        check("pot_update_count", upd_q.size(), 1);
        if (upd_q.size() > 0) begin
            check("pot_pre", int'(upd_q[0].pre), 2);
            check("pot_post", int'(upd_q[0].post), 0);
            check("pot_dt", int'($signed(upd_q[0].dt)), 4);
        end
`ifdef STDP_PERF_CNT_EN
        check("perf_pair_count", pair_count, 8);
        check("perf_upd_count", upd_count, 1);
`endif
        @(negedge clk);

        // Depression at (1,1) with backpressure for 5 cycles
        load_hist(16'h0, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h2000);
        upd_q.delete();
        upd_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 1;
        while (!upd_valid && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        check("dep_valid_seen", upd_valid, 1);
        vcycles = 0;
        stable = 1'b1;
        while (upd_valid && vcycles < 20) begin
            vcycles++;
            if (upd_pre != 2'd1 || upd_post != 1'b1 || upd_dt != 6'sb111110) stable = 1'b0;
            if (vcycles == 6) upd_ready = 1'b1;
            @(negedge clk);
            cycles++;
        end
        upd_ready = 1'b1;
        check("dep_valid_cycles", vcycles, 6);
        check("dep_payload_stable", stable, 1);
        while (!done && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        check("dep_done_latency", cycles, 31);
        check("dep_update_count", upd_q.size(), 1);
        if (upd_q.size() > 0) begin
            check("dep_dt", int'($signed(upd_q[0].dt)), -2);
        end
        @(negedge clk);
        check("dep_dif_pre_hold", dif_pre, 16'h0);
        check("dep_dif_post_hold", dif_post, 16'h2000);

        // Coincident spikes at (0,0) give dt=0
        load_hist(16'h8000, 16'h0, 16'h0, 16'h0, 16'h8000, 16'h0);
        upd_q.delete();
        run_scan(100, 0, cycles, busy_n);
        check("coinc_done_latency", cycles, 25);
        check("coinc_no_updates", upd_q.size(), 0);
        @(negedge clk);

        // Abort during ISSUE, then rescan from (0,0)
        load_hist(16'h0, 16'h0, 16'h0800, 16'h0, 16'h8000, 16'h0);
        upd_q.delete();
        upd_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!upd_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("abort_valid_seen", upd_valid, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid_drop", upd_valid, 0);
        check("abort_busy_drop", busy, 0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);
        check("abort_no_handshake", upd_q.size(), 0);
        upd_ready = 1'b1;
        addr_q.delete();
        run_scan(100, 0, cycles, busy_n);
        check("rescan_done_latency", cycles, 26);
        check("rescan_first_addr", (addr_q.size() > 0) ? addr_q[0] : -1, 0);
        check("rescan_update_count", upd_q.size(), 1);
        @(negedge clk);

        // Start pulse while busy is ignored
        addr_q.delete();
        upd_q.delete();
        run_scan(100, 7, cycles, busy_n);
        check("restart_done_latency", cycles, 26);
        check("restart_read_count", addr_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("restart_order_%0d", i), (i < addr_q.size()) ? addr_q[i] : -1,
                  (i % 4) + 16 * (i / 4));
        end
        @(negedge clk);

        // Asynchronous reset in the READ of pair (0,1)
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!(hist_rd_en && post_addr == 1'b1) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("arst_reached_read", {hist_rd_en, post_addr}, 2'b11);
        check("arst_dif_post_before", dif_post, 16'h8000);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_rd_en", hist_rd_en, 0);
        check("arst_post_addr", post_addr, 0);
        check("arst_dif_post", dif_post, 0);
        check("arst_upd_valid", upd_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
